// File: rtl/keyboard.sv
// rtl/keyboard.sv - PS/2 scan-code events to ZX Spectrum 8x5 keyboard matrix with port-FE read path.
// State vector: [39:0] physical keys (row*5+bit, index 0 = left shift), [40] right shift, [48:41] compound flags.
module keyboard (
   input  logic       clock,
   input  logic       reset,
   input  logic       strb,
   input  logic       make,
   input  logic [7:0] code,
   input  logic [7:0] addr,
   output logic [4:0] keys,
   output logic       pressed
);

   localparam int NST = 49;

   logic [NST-1:0] st_q, st_d;
   logic           hit;
   logic [5:0]     idx;
   logic [39:0]    mat;
   logic [4:0]     col;

   always_comb begin
      hit = 1'b1;
      idx = 6'd0;
      case (code)
         8'h12: idx = 6'd0;   8'h1A: idx = 6'd1;   8'h22: idx = 6'd2;   8'h21: idx = 6'd3;
         8'h2A: idx = 6'd4;   8'h1C: idx = 6'd5;   8'h1B: idx = 6'd6;   8'h23: idx = 6'd7;
         8'h2B: idx = 6'd8;   8'h34: idx = 6'd9;   8'h15: idx = 6'd10;  8'h1D: idx = 6'd11;
         8'h24: idx = 6'd12;  8'h2D: idx = 6'd13;  8'h2C: idx = 6'd14;  8'h16: idx = 6'd15;
         8'h1E: idx = 6'd16;  8'h26: idx = 6'd17;  8'h25: idx = 6'd18;  8'h2E: idx = 6'd19;
         8'h45: idx = 6'd20;  8'h46: idx = 6'd21;  8'h3E: idx = 6'd22;  8'h3D: idx = 6'd23;
         8'h36: idx = 6'd24;  8'h4D: idx = 6'd25;  8'h44: idx = 6'd26;  8'h43: idx = 6'd27;
         8'h3C: idx = 6'd28;  8'h35: idx = 6'd29;  8'h5A: idx = 6'd30;  8'h4B: idx = 6'd31;
         8'h42: idx = 6'd32;  8'h3B: idx = 6'd33;  8'h33: idx = 6'd34;  8'h29: idx = 6'd35;
         8'h14: idx = 6'd36;  8'h3A: idx = 6'd37;  8'h31: idx = 6'd38;  8'h32: idx = 6'd39;
         8'h59: idx = 6'd40;
         8'h66: idx = 6'd41;  8'h6B: idx = 6'd42;  8'h72: idx = 6'd43;  8'h75: idx = 6'd44;
         8'h74: idx = 6'd45;  8'h76: idx = 6'd46;  8'h41: idx = 6'd47;  8'h49: idx = 6'd48;
         default: hit = 1'b0;
      endcase
   end

   // Writing !make is naturally idempotent for repeats and stray breaks.
   always_comb begin
      st_d = st_q;
      if (strb && hit) begin
         st_d[idx] = !make;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st_q <= '0;
      end else begin
         st_q <= st_d;
      end
   end

   // Compound flags OR into the physical bits; CAPS also takes the right shift.
   always_comb begin
      mat     = st_q[39:0];
      mat[0]  = st_q[0] | st_q[40] | (|st_q[46:41]);
      mat[20] = st_q[20] | st_q[41];
      mat[19] = st_q[19] | st_q[42];
      mat[24] = st_q[24] | st_q[43];
      mat[23] = st_q[23] | st_q[44];
      mat[22] = st_q[22] | st_q[45];
      mat[35] = st_q[35] | st_q[46];
      mat[36] = st_q[36] | st_q[47] | st_q[48];
      mat[38] = st_q[38] | st_q[47];
      mat[37] = st_q[37] | st_q[48];
   end

   always_comb begin
      col = 5'd0;
      for (int r = 0; r < 8; r++) begin
         if (!addr[r]) begin
            col = col | mat[r*5 +: 5];
         end
      end
      keys    = ~col;
      pressed = |mat;
   end

endmodule
